// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: round-robin arbiter of FU results onto one registered writeback slot.
// Define WB_ARB_FIXED_PRIO_EN to make the lowest valid index always win.
module wb_port_arbiter #(
    parameter int NR_REQ = 8,
    parameter int DATA_W = 142,
    localparam int SW = NR_REQ > 1 ? $clog2(NR_REQ) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic [NR_REQ-1:0]        req_valid_i,
    input  logic [NR_REQ*DATA_W-1:0] req_data_i,
    output logic [NR_REQ-1:0]        req_ready_o,
    output logic                     wb_valid_o,
    output logic [DATA_W-1:0]        wb_data_o,
    output logic [SW-1:0]            wb_src_o,
    input  logic                     wb_ready_i
);
    logic              slot_free;
    logic              found;
    logic              grant;
    logic [SW-1:0]     gnt_idx;
    logic [SW-1:0]     rr_ptr;
    logic [SW:0]       sum;
    logic [NR_REQ-1:0] rot;

    assign slot_free = !wb_valid_o || wb_ready_i;
    // rot[k] is the valid bit of requester rr_ptr+k (mod NR_REQ)
    assign rot = NR_REQ'({req_valid_i, req_valid_i} >> rr_ptr);

    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        sum     = '0;
        for (int k = NR_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found   = 1'b1;
                sum     = {1'b0, rr_ptr} + (SW+1)'(k);
                gnt_idx = SW'(sum >= (SW+1)'(NR_REQ) ? sum - (SW+1)'(NR_REQ) : sum);
            end
        end
    end

    assign grant       = slot_free && !flush_i && !rst_i && found;
    assign req_ready_o = grant ? NR_REQ'(1) << gnt_idx : '0;

`ifdef WB_ARB_FIXED_PRIO_EN
    assign rr_ptr = '0;
`else
    always_ff @(posedge clk_i) begin
        if (rst_i)
            rr_ptr <= '0;
        else if (grant)
            rr_ptr <= gnt_idx == SW'(NR_REQ - 1) ? '0 : gnt_idx + 1'b1;
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wb_valid_o <= 1'b0;
            wb_data_o  <= '0;
            wb_src_o   <= '0;
        end else if (flush_i) begin
            wb_valid_o <= 1'b0;
        end else if (grant) begin
            wb_valid_o <= 1'b1;
            wb_data_o  <= req_data_i[int'(gnt_idx)*DATA_W +: DATA_W];
            wb_src_o   <= gnt_idx;
        end else if (wb_ready_i) begin
            wb_valid_o <= 1'b0;
        end
    end
endmodule
